// File: rtl/core_s2_exec.sv
// LETC stage-2 execute unit: registered single-cycle ALU behind a valid/ready handshake.
// Define LETC_CORE_S2_EXEC_MUL_EN to execute ops 10-13 on an iterative shift-add multiplier.
module core_s2_exec #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_op,
  input  logic [XLEN-1:0]      in_operand_1,
  input  logic [XLEN-1:0]      in_operand_2,
  input  logic [REG_IDX_W-1:0] in_rd_idx,
  input  logic                 in_rd_we,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_result,
  output logic [REG_IDX_W-1:0] out_rd_idx,
  output logic                 out_rd_we,
  output logic                 out_illegal,
  output logic                 busy
);

  localparam int SHW = $clog2(XLEN);

  logic                 idle;
  logic                 accept;
  logic                 isMul;
  logic                 aluIllegal;
  logic [XLEN-1:0]      aluRes;
  logic [SHW-1:0]       shamt;

  logic                 mulDone;
  logic [XLEN-1:0]      mulRes;
  logic [REG_IDX_W-1:0] mulRdIdx;
  logic                 mulRdWe;

  logic                 outValid_q, outValid_d;
  logic [XLEN-1:0]      outResult_q, outResult_d;
  logic [REG_IDX_W-1:0] outRdIdx_q, outRdIdx_d;
  logic                 outRdWe_q, outRdWe_d;
  logic                 outIllegal_q, outIllegal_d;

  assign shamt    = in_operand_2[SHW-1:0];
  assign in_ready = idle && (!outValid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    aluRes     = '0;
    aluIllegal = 1'b0;
    isMul      = 1'b0;
    case (in_op)
      4'd0:  aluRes = in_operand_1 + in_operand_2;
      4'd1:  aluRes = in_operand_1 - in_operand_2;
      4'd2:  aluRes = in_operand_1 << shamt;
      4'd3:  aluRes = {{(XLEN-1){1'b0}}, $signed(in_operand_1) < $signed(in_operand_2)};
      4'd4:  aluRes = {{(XLEN-1){1'b0}}, in_operand_1 < in_operand_2};
      4'd5:  aluRes = in_operand_1 ^ in_operand_2;
      4'd6:  aluRes = in_operand_1 >> shamt;
      4'd7:  aluRes = $signed(in_operand_1) >>> shamt;
      4'd8:  aluRes = in_operand_1 | in_operand_2;
      4'd9:  aluRes = in_operand_1 & in_operand_2;
      4'd10, 4'd11, 4'd12, 4'd13: begin
`ifdef LETC_CORE_S2_EXEC_MUL_EN
        isMul = 1'b1;
`else
        aluIllegal = 1'b1;
`endif
      end
      default: aluIllegal = 1'b1;
    endcase
  end

`ifdef LETC_CORE_S2_EXEC_MUL_EN
  localparam int CNTW = $clog2(XLEN) + 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [2*XLEN-1:0]    mcand_q, mcand_d;
  logic [2*XLEN-1:0]    acc_q, acc_d;
  logic [2*XLEN-1:0]    partial, accStep;
  logic [XLEN-1:0]      mplier_q, mplier_d;
  logic                 bSigned_q, bSigned_d;
  logic                 wantHi_q, wantHi_d;
  logic [REG_IDX_W-1:0] pendIdx_q, pendIdx_d;
  logic                 pendWe_q, pendWe_d;
  logic                 aSigned;

  assign aSigned = (in_op == 4'd11) || (in_op == 4'd12);
  assign partial = mplier_q[0] ? mcand_q : '0;
  // A signed multiplier's MSB has negative weight, so its (final) step subtracts.
  assign accStep = (bSigned_q && cnt_q == CNTW'(1)) ? acc_q - partial : acc_q + partial;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      bSigned_q <= 1'b0;
      wantHi_q  <= 1'b0;
      pendIdx_q <= '0;
      pendWe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      bSigned_q <= bSigned_d;
      wantHi_q  <= wantHi_d;
      pendIdx_q <= pendIdx_d;
      pendWe_q  <= pendWe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    bSigned_d = bSigned_q;
    wantHi_d  = wantHi_q;
    pendIdx_d = pendIdx_q;
    pendWe_d  = pendWe_q;
    mulDone   = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      if (accept && isMul) begin
        state_d   = BUSY;
        cnt_d     = CNTW'(XLEN);
        mcand_d   = {{XLEN{aSigned & in_operand_1[XLEN-1]}}, in_operand_1};
        acc_d     = '0;
        mplier_d  = in_operand_2;
        bSigned_d = (in_op == 4'd11);
        wantHi_d  = (in_op != 4'd10);
        pendIdx_d = in_rd_idx;
        pendWe_d  = in_rd_we;
      end
    end else begin
      acc_d    = accStep;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNTW'(1);
      if (cnt_q == CNTW'(1)) begin
        mulDone = 1'b1;
        state_d = IDLE;
      end
    end
  end

  assign idle     = (state_q == IDLE);
  assign busy     = (state_q == BUSY);
  assign mulRes   = wantHi_q ? accStep[2*XLEN-1:XLEN] : accStep[XLEN-1:0];
  assign mulRdIdx = pendIdx_q;
  assign mulRdWe  = pendWe_q;
`else
  assign idle     = 1'b1;
  assign busy     = 1'b0;
  assign mulDone  = 1'b0;
  assign mulRes   = '0;
  assign mulRdIdx = '0;
  assign mulRdWe  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outValid_q   <= 1'b0;
      outResult_q  <= '0;
      outRdIdx_q   <= '0;
      outRdWe_q    <= 1'b0;
      outIllegal_q <= 1'b0;
    end else begin
      outValid_q   <= outValid_d;
      outResult_q  <= outResult_d;
      outRdIdx_q   <= outRdIdx_d;
      outRdWe_q    <= outRdWe_d;
      outIllegal_q <= outIllegal_d;
    end
  end

  // A new load wins over the handshake clear, which keeps back-to-back ops at full rate.
  always_comb begin
    outValid_d   = outValid_q;
    outResult_d  = outResult_q;
    outRdIdx_d   = outRdIdx_q;
    outRdWe_d    = outRdWe_q;
    outIllegal_d = outIllegal_q;
    if (flush) begin
      outValid_d   = 1'b0;
      outIllegal_d = 1'b0;
    end else if (mulDone) begin
      outValid_d   = 1'b1;
      outResult_d  = mulRes;
      outRdIdx_d   = mulRdIdx;
      outRdWe_d    = mulRdWe;
      outIllegal_d = 1'b0;
    end else if (accept && !isMul) begin
      outValid_d   = 1'b1;
      outResult_d  = aluIllegal ? '0 : aluRes;
      outRdIdx_d   = in_rd_idx;
      outRdWe_d    = in_rd_we && !aluIllegal;
      outIllegal_d = aluIllegal;
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  assign out_valid   = outValid_q;
  assign out_result  = outResult_q;
  assign out_rd_idx  = outRdIdx_q;
  assign out_rd_we   = outRdWe_q;
  assign out_illegal = outIllegal_q;

endmodule

// File: tb/tb_core_s2_exec.sv
// Self-checking bench for core_s2_exec: directed scenarios plus a randomized run against a
// transaction-level model (latency-tagged result queue). Honours LETC_CORE_S2_EXEC_MUL_EN.
module tb_core_s2_exec;

  localparam int XLEN = 32;
  localparam int RW   = 5;
`ifdef LETC_CORE_S2_EXEC_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  idx;
    logic        we;
    logic        ill;
    logic        isMul;
    int          due;
  } expEntry_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            inValid;
  logic            inReady;
  logic [3:0]      inOp;
  logic [31:0]     inA;
  logic [31:0]     inB;
  logic [RW-1:0]   inRdIdx;
  logic            inRdWe;
  logic            outValid;
  logic            outReady;
  logic [31:0]     outResult;
  logic [RW-1:0]   outRdIdx;
  logic            outRdWe;
  logic            outIllegal;
  logic            busy;

  int checks = 0;
  int errors = 0;

  core_s2_exec #(.XLEN(XLEN), .REG_IDX_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(inValid), .in_ready(inReady), .in_op(inOp),
    .in_operand_1(inA), .in_operand_2(inB), .in_rd_idx(inRdIdx), .in_rd_we(inRdWe),
    .out_valid(outValid), .out_ready(outReady), .out_result(outResult),
    .out_rd_idx(outRdIdx), .out_rd_we(outRdWe), .out_illegal(outIllegal), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd, input logic we);
    inValid = v;
    inOp    = op;
    inA     = a;
    inB     = b;
    inRdIdx = rd;
    inRdWe  = we;
  endtask

  // Reference semantics from 64-bit integer arithmetic.
  function automatic void refExec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sh = int'(b % 32);
    ill = 1'b0;
    r = '0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a << sh;
      4'd3: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd4: r = (ua < ub) ? 32'd1 : 32'd0;
      4'd5: r = a ^ b;
      4'd6: r = a >> sh;
      4'd7: begin p = 64'(sa >>> sh); r = p[31:0]; end
      4'd8: r = a | b;
      4'd9: r = a & b;
      4'd10: begin p = 64'(ua * ub); r = p[31:0]; ill = !MulEn; end
      4'd11: begin p = 64'(sa * sb); r = p[63:32]; ill = !MulEn; end
      4'd12: begin p = 64'(sa * ub); r = p[63:32]; ill = !MulEn; end
      4'd13: begin p = 64'(ua * ub); r = p[63:32]; ill = !MulEn; end
      default: ill = 1'b1;
    endcase
    if (ill) r = '0;
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    outReady = 1'b1;
    applyStimulus(1'b1, 4'd0, 32'd1, 32'd2, 5'd7, 1'b1);
    repeat (3) tick();
    checks++;
    if ({outValid, outResult, outRdIdx, outRdWe, outIllegal, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got v=%0b r=%h idx=%0d we=%0b ill=%0b busy=%0b want all 0",
               outValid, outResult, outRdIdx, outRdWe, outIllegal, busy);
    end
    inValid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release got v=%0b rdy=%0b want v=0 rdy=1", outValid, inReady);
    end
  endtask

  task automatic test_add();
    outReady = 1'b1;
    applyStimulus(1'b1, 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3, 1'b1);
    #1;
    checks++;
    if (inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_ready got %0b want 1", inReady);
    end
    tick();
    inValid = 1'b0;
    checks++;
    if ({outValid, outResult, outRdIdx, outRdWe, outIllegal} !== {1'b1, 32'h8000_0000, 5'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL add_result got v=%0b r=%h idx=%0d we=%0b ill=%0b want v=1 r=80000000 idx=3 we=1 ill=0",
               outValid, outResult, outRdIdx, outRdWe, outIllegal);
    end
    tick();
    checks++;
    if (outValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_drain got v=%0b want 0", outValid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  opTab[3]  = '{4'd1, 4'd7, 4'd4};
    logic [31:0] aTab[3]   = '{32'd5, 32'h8000_0000, 32'd1};
    logic [31:0] bTab[3]   = '{32'd7, 32'h24, 32'hFFFF_FFFF};
    logic [31:0] expTab[3] = '{32'hFFFF_FFFE, 32'hF800_0000, 32'h0000_0001};
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, opTab[i], aTab[i], bTab[i], 5'(i + 10), 1'b1);
      #1;
      checks++;
      if (inReady !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_ready[%0d] got %0b want 1", i, inReady);
      end
      tick();
      checks++;
      if (outValid !== 1'b1 || outResult !== expTab[i] || outRdIdx !== 5'(i + 10)) begin
        errors++;
        $display("[TB] FAIL b2b_result[%0d] got v=%0b r=%h idx=%0d want v=1 r=%h idx=%0d",
                 i, outValid, outResult, outRdIdx, expTab[i], i + 10);
      end
    end
    inValid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    outReady = 1'b1;
    applyStimulus(1'b1, 4'd5, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 5'd4, 1'b1);
    tick();
    outReady = 1'b0;
    applyStimulus(1'b1, 4'd9, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd6, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (inReady !== 1'b0 || outValid !== 1'b1 || outResult !== 32'hAAAA_AAAA || outRdIdx !== 5'd4) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d] got rdy=%0b v=%0b r=%h idx=%0d want rdy=0 v=1 r=aaaaaaaa idx=4",
                 i, inReady, outValid, outResult, outRdIdx);
      end
      tick();
    end
    outReady = 1'b1;
    #1;
    checks++;
    if (inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release_ready got %0b want 1", inReady);
    end
    tick();
    inValid = 1'b0;
    checks++;
    if (outValid !== 1'b1 || outResult !== 32'hF0F0_0000 || outRdIdx !== 5'd6) begin
      errors++;
      $display("[TB] FAIL stall_next got v=%0b r=%h idx=%0d want v=1 r=f0f00000 idx=6",
               outValid, outResult, outRdIdx);
    end
    tick();
  endtask

  task automatic test_illegal();
`ifdef LETC_CORE_S2_EXEC_MUL_EN
    logic [3:0] opTab[2] = '{4'd15, 4'd14};
`else
    logic [3:0] opTab[2] = '{4'd15, 4'd10};
`endif
    outReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, opTab[i], 32'h1234_5678, 32'h0000_0003, 5'd9, 1'b1);
      tick();
      inValid = 1'b0;
      checks++;
      if ({outValid, outIllegal, outRdWe, outResult} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
        errors++;
        $display("[TB] FAIL illegal_op%0d got v=%0b ill=%0b we=%0b r=%h want v=1 ill=1 we=0 r=0",
                 opTab[i], outValid, outIllegal, outRdWe, outResult);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    outReady = 1'b0;
    applyStimulus(1'b1, 4'd14, 32'd1, 32'd1, 5'd2, 1'b1);
    tick();
    flush = 1'b1;
    applyStimulus(1'b1, 4'd1, 32'd9, 32'd4, 5'd5, 1'b1);
    #1;
    checks++;
    if (inReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_ready got %0b want 0", inReady);
    end
    tick();
    flush = 1'b0;
    inValid = 1'b0;
    checks++;
    if (outValid !== 1'b0 || outIllegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_clear got v=%0b ill=%0b want v=0 ill=0", outValid, outIllegal);
    end
    tick();
    checks++;
    if (outValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_no_accept got v=%0b want 0", outValid);
    end
    outReady = 1'b1;
  endtask

  task automatic test_reset_hold();
    outReady = 1'b0;
    applyStimulus(1'b1, 4'd8, 32'hFF00_0000, 32'h0000_00FF, 5'd17, 1'b1);
    tick();
    inValid = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({outValid, outResult, outRdIdx, outRdWe, outIllegal, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_hold got v=%0b r=%h idx=%0d we=%0b ill=%0b busy=%0b want all 0",
               outValid, outResult, outRdIdx, outRdWe, outIllegal, busy);
    end
    rst_n = 1'b1;
    outReady = 1'b1;
    tick();
  endtask

`ifdef LETC_CORE_S2_EXEC_MUL_EN
  task automatic test_mul();
    logic [3:0]  opTab[3]  = '{4'd11, 4'd13, 4'd10};
    logic [31:0] expTab[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};
    int waited;
    int busyCnt;
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, opTab[i], 32'hFFFF_FFFF, 32'h0000_0002, 5'd12, 1'b1);
      tick();
      inValid = 1'b0;
      waited = 1;
      busyCnt = 0;
      while (outValid !== 1'b1 && waited < 60) begin
        if (busy === 1'b1) busyCnt++;
        tick();
        waited++;
      end
      checks++;
      if (outValid !== 1'b1 || waited != 33 || busyCnt != 32 || outResult !== expTab[i] || outRdWe !== 1'b1) begin
        errors++;
        $display("[TB] FAIL mul_op%0d got v=%0b lat=%0d busy=%0d r=%h we=%0b want v=1 lat=33 busy=32 r=%h we=1",
                 opTab[i], outValid, waited, busyCnt, outResult, outRdWe, expTab[i]);
      end
      tick();
    end
  endtask

  task automatic test_mul_abort();
    bit seen;
    outReady = 1'b1;
    applyStimulus(1'b1, 4'd10, 32'd1234, 32'd5678, 5'd8, 1'b1);
    tick();
    inValid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || outValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mul_flush got busy=%0b v=%0b want busy=0 v=0", busy, outValid);
    end
    seen = 1'b0;
    repeat (40) begin
      if (outValid === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mul_flush_no_result got stray result=1 want 0");
    end
    applyStimulus(1'b1, 4'd0, 32'd2, 32'd3, 5'd1, 1'b1);
    tick();
    inValid = 1'b0;
    checks++;
    if (outValid !== 1'b1 || outResult !== 32'd5) begin
      errors++;
      $display("[TB] FAIL mul_flush_after_add got v=%0b r=%h want v=1 r=5", outValid, outResult);
    end
    tick();
    applyStimulus(1'b1, 4'd11, 32'hDEAD_BEEF, 32'h1357_9BDF, 5'd30, 1'b1);
    tick();
    inValid = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({outValid, outResult, outRdIdx, outRdWe, outIllegal, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL mul_reset got v=%0b r=%h idx=%0d we=%0b ill=%0b busy=%0b want all 0",
               outValid, outResult, outRdIdx, outRdWe, outIllegal, busy);
    end
    rst_n = 1'b1;
    tick();
  endtask
`endif

  task automatic test_random();
    expEntry_t q[$];
    expEntry_t e;
    logic [31:0] r;
    logic ill;
    logic expValid, expReady, expBusy;
    int cyc;
    int op;
    bit draining;
    cyc = 0;
    while (cyc < 2500) begin
      draining = (cyc >= 2000);
      if (draining && q.size() == 0) break;
      if (draining) begin
        inValid = 1'b0;
        flush = 1'b0;
        outReady = 1'b1;
      end else begin
        op = $urandom_range(0, 15);
        if (op >= 10 && op <= 13 && $urandom_range(0, 3) != 0) op = op - 10;
        applyStimulus($urandom_range(0, 3) != 0, 4'(op), randOperand(), randOperand(),
                      5'($urandom), 1'($urandom));
        outReady = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 60) == 0);
      end
      #1;
      expValid = (q.size() > 0) && (cyc >= q[0].due);
      expBusy  = (q.size() > 0) && q[0].isMul && (cyc < q[0].due);
      expReady = !flush && !expBusy && (!expValid || outReady);
      checks++;
      if (outValid !== expValid || inReady !== expReady || busy !== expBusy) begin
        errors++;
        $display("[TB] FAIL rand_ctrl cyc=%0d got v=%0b rdy=%0b busy=%0b want v=%0b rdy=%0b busy=%0b",
                 cyc, outValid, inReady, busy, expValid, expReady, expBusy);
      end
      if (expValid) begin
        checks++;
        if ({outResult, outRdIdx, outRdWe, outIllegal} !== {q[0].res, q[0].idx, q[0].we, q[0].ill}) begin
          errors++;
          $display("[TB] FAIL rand_data cyc=%0d got r=%h idx=%0d we=%0b ill=%0b want r=%h idx=%0d we=%0b ill=%0b",
                   cyc, outResult, outRdIdx, outRdWe, outIllegal, q[0].res, q[0].idx, q[0].we, q[0].ill);
        end
        if (outReady) void'(q.pop_front());
      end
      if (flush) begin
        q.delete();
      end else if (inValid && expReady) begin
        refExec(inOp, inA, inB, r, ill);
        e.res   = r;
        e.idx   = inRdIdx;
        e.we    = inRdWe && !ill;
        e.ill   = ill;
        e.isMul = !ill && (inOp >= 4'd10) && (inOp <= 4'd13);
        e.due   = cyc + (e.isMul ? XLEN + 1 : 1);
        q.push_back(e);
      end
      tick();
      cyc++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rand_drain got %0d pending want 0", q.size());
    end
    flush = 1'b0;
    inValid = 1'b0;
    outReady = 1'b1;
    tick();
  endtask

  initial begin
    $display("[TB] core_s2_exec bench start, multiplier %0s", MulEn ? "enabled" : "disabled");
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_flush();
    test_reset_hold();
`ifdef LETC_CORE_S2_EXEC_MUL_EN
    test_mul();
    test_mul_abort();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
